// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_BURST = 4;

    // Index width with a floor of one bit so single-value ranges still get a port.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request after index 'last'.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        // Scan last+1 .. last+NREQ modulo NREQ; only indices below NREQ are reachable.
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!any && req[j]) begin
                any     = 1'b1;
                idx     = IW'(j);
                pick[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters,
// with optional burst locking of the current owner.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no owner locked; next grant goes to round-robin pick
//   ST_BURST | owner_q holds the port while it requests, up to MAX_BURST
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST,
    localparam int IW       = clog2(NREQ),
    localparam int CW       = clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic             fifo_full,
    output logic [NREQ-1:0]  gnt,
    output logic             wr,
    output logic [DW-1:0]    data_out,
    output logic             busy,
    output logic [IW-1:0]    owner
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic [NREQ-1:0] rr_pick;
    logic [IW-1:0]   rr_idx;
    logic            rr_any;

    logic            hold;
    logic            any_cand;
    logic [IW-1:0]   cand_idx;
    logic            grant;

    rr_picker #(.NREQ(NREQ)) u_rr_picker (
        .req  (req),
        .last (last_q),
        .pick (rr_pick),
        .idx  (rr_idx),
        .any  (rr_any)
    );

    always_comb begin
        hold     = (state_q == ST_BURST) && req[owner_q];
        cand_idx = hold ? owner_q : rr_idx;
        any_cand = hold | rr_any;
        // rst_n gates the grant so a word presented during reset is never acknowledged.
        grant    = any_cand & ~fifo_full & rst_n;

        gnt      = '0;
        data_out = '0;
        if (grant) begin
            gnt      = hold ? (NREQ'(1) << owner_q) : rr_pick;
            data_out = wdata[cand_idx*DW +: DW];
        end
        wr    = grant;
        busy  = (state_q == ST_BURST);
        owner = owner_q;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        if (grant) begin
            if (hold) begin
                if (cnt_q == CW'(MAX_BURST - 1)) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                owner_d = cand_idx;
                if (MAX_BURST == 1) begin
                    state_d = ST_IDLE;
                    last_d  = cand_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_BURST;
                    cnt_d   = CW'(1);
                end
            end
        end else if ((state_q == ST_BURST) && !req[owner_q]) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_wr_not_full: assert property (@(posedge clk) disable iff (!rst_n) wr |-> !fifo_full);
    a_wr_is_gnt: assert property (@(posedge clk) disable iff (!rst_n) wr == (|gnt));

endmodule
